// File: rtl/cfg_avmm_resp.sv
// rtl/cfg_avmm_resp.sv - Avalon-MM config responder: ID/status/control register bank for one AIB channel.
// Optional error counter in reg0[31:16] when CFG_AVMM_RESP_ERRCNT_EN is defined.
module cfg_avmm_resp #(
  parameter logic [6:0]  BASE_ADDR    = 7'h00,
  parameter int          NUM_REGS     = 8,
  parameter int          RD_LATENCY   = 2,
  parameter logic [31:0] ID_VAL       = 32'hA1B0_0001,
  parameter logic [31:0] CTRL_RST_VAL = 32'h0
) (
  input  logic                          i_cfg_avmm_clk,
  input  logic                          i_cfg_avmm_rst,
  input  logic [16:0]                   i_cfg_avmm_addr,
  input  logic [3:0]                    i_cfg_avmm_byte_en,
  input  logic                          i_cfg_avmm_read,
  input  logic                          i_cfg_avmm_write,
  input  logic [31:0]                   i_cfg_avmm_wdata,
  input  logic [31:0]                   i_status,
  output logic [31:0]                   o_cfg_avmm_rdata,
  output logic                          o_cfg_avmm_rdatavld,
  output logic                          o_cfg_avmm_waitreq,
  output logic [32*(NUM_REGS-2)-1:0]    o_ctrl_regs
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int NC = NUM_REGS - 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACK    = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  logic [1:0]            state;
  logic [AW-1:0]         widx;
  logic                  sel;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [31:0]           ctrl_q [NC];
  logic [31:0]           status_q;
  logic [31:0]           pipe_d [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_v;
  logic [31:0]           id_word;
  logic [31:0]           rd_word;
  logic                  unused_addr;

  assign widx = i_cfg_avmm_addr[2+AW-1:2];
  assign sel  = (i_cfg_avmm_read | i_cfg_avmm_write) && (i_cfg_avmm_addr[16:10] == BASE_ADDR);

  // Acceptance happens only in ACK; a dropped request there performs nothing. Write wins a collision.
  assign acc_wr = (state == ST_ACK) && sel && i_cfg_avmm_write;
  assign acc_rd = (state == ST_ACK) && sel && !i_cfg_avmm_write;

  assign o_cfg_avmm_waitreq  = (state != ST_ACK);
  assign o_cfg_avmm_rdata    = pipe_d[RD_LATENCY-1];
  assign o_cfg_avmm_rdatavld = pipe_v[RD_LATENCY-1];
  assign unused_addr         = ^i_cfg_avmm_addr[9:0];

  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (sel) state <= ST_ACK;
        ST_ACK:    state <= acc_rd ? ST_RDWAIT : ST_IDLE;
        ST_RDWAIT: if (pipe_v[RD_LATENCY-1]) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      status_q <= 32'h0;
    end else begin
      status_q <= i_status;
    end
  end

  // Data stages only load behind a valid, so the last stage holds rdata between pulses.
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_d[i] <= 32'h0;
    end else begin
      pipe_v[0] <= acc_rd;
      if (acc_rd) pipe_d[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      for (int i = 0; i < NC; i++) ctrl_q[i] <= CTRL_RST_VAL;
    end else if (acc_wr) begin
      for (int i = 0; i < NC; i++) begin
        if (widx == AW'(i + 2)) begin
          for (int b = 0; b < 4; b++) begin
            if (i_cfg_avmm_byte_en[b]) ctrl_q[i][8*b +: 8] <= i_cfg_avmm_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = 32'h0;
    if (widx == AW'(0)) begin
      rd_word = id_word;
    end else if (widx == AW'(1)) begin
      rd_word = status_q;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (widx == AW'(i + 2)) rd_word = ctrl_q[i];
      end
    end
  end

`ifdef CFG_AVMM_RESP_ERRCNT_EN
  logic [15:0] err_cnt;
  logic        err_evt;
  logic        err_clr;

  assign err_evt = acc_wr && ((widx < AW'(2)) || i_cfg_avmm_read);
  assign err_clr = acc_wr && (widx == AW'(0)) && (|i_cfg_avmm_byte_en[3:2]);

  // Clear takes priority, so an event coinciding with the clear is dropped.
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      err_cnt <= 16'h0;
    end else if (err_clr) begin
      err_cnt <= 16'h0;
    end else if (err_evt && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h1;
    end
  end

  assign id_word = {err_cnt, ID_VAL[15:0]};
`else
  assign id_word = ID_VAL;
`endif

  for (genvar g = 0; g < NC; g++) begin : g_ctrl_out
    assign o_ctrl_regs[32*g +: 32] = ctrl_q[g];
  end

endmodule

// File: tb/tb_cfg_avmm_resp.sv
// tb/tb_cfg_avmm_resp.sv - directed self-checking bench for cfg_avmm_resp (default build).
module tb_cfg_avmm_resp;

  logic         clk;
  logic         rst;
  logic [16:0]  addr;
  logic [3:0]   be;
  logic         rd;
  logic         wr;
  logic [31:0]  wdata;
  logic [31:0]  status;
  logic [31:0]  rdata;
  logic         rdatavld;
  logic         waitreq;
  logic [191:0] ctrl_regs;

  int n_cmp = 0;
  int n_err = 0;

  cfg_avmm_resp dut (
    .i_cfg_avmm_clk      (clk),
    .i_cfg_avmm_rst      (rst),
    .i_cfg_avmm_addr     (addr),
    .i_cfg_avmm_byte_en  (be),
    .i_cfg_avmm_read     (rd),
    .i_cfg_avmm_write    (wr),
    .i_cfg_avmm_wdata    (wdata),
    .i_status            (status),
    .o_cfg_avmm_rdata    (rdata),
    .o_cfg_avmm_rdatavld (rdatavld),
    .o_cfg_avmm_waitreq  (waitreq),
    .o_ctrl_regs         (ctrl_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitreq !== 1'b0 && n < 20);
    chk({tag, " ack"}, {31'h0, waitreq}, 32'h0);
  endtask

  task automatic do_write(input string tag, input logic [16:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic also_rd);
    @(negedge clk);
    addr = a; wdata = d; be = b; wr = 1'b1; rd = also_rd;
    wait_ack(tag);
    @(posedge clk);
    #1 wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    chk({tag, " waitreq_after"}, {31'h0, waitreq}, 32'h1);
  endtask

  task automatic do_read(input string tag, input logic [16:0] a, input logic [31:0] exp);
    int k = 0;
    @(negedge clk);
    addr = a; rd = 1'b1;
    wait_ack(tag);
    @(posedge clk);
    #1 rd = 1'b0;
    do begin
      @(negedge clk);
      k++;
    end while (rdatavld !== 1'b1 && k < 8);
    chk({tag, " latency"}, 32'(k), 32'd2);
    chk({tag, " rdata"}, rdata, exp);
    @(negedge clk);
    chk({tag, " pulse_end"}, {31'h0, rdatavld}, 32'h0);
    chk({tag, " rdata_hold"}, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; addr = '0; be = '0; rd = 1'b0; wr = 1'b0; wdata = '0; status = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset waitreq", {31'h0, waitreq}, 32'h1);
    chk("reset rdatavld", {31'h0, rdatavld}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    for (int i = 0; i < 6; i++) chk("reset ctrl", ctrl_regs[32*i +: 32], 32'h0);

    do_write("wr_reg2", 17'h0008, 32'h1234_5678, 4'b1111, 1'b0);
    chk("wr_reg2 value", ctrl_regs[31:0], 32'h1234_5678);
    do_read("rd_reg2", 17'h0008, 32'h1234_5678);

    do_write("merge", 17'h0008, 32'hAABB_CCDD, 4'b0101, 1'b0);
    chk("merge value", ctrl_regs[31:0], 32'h12BB_56DD);
    do_read("rd_merge", 17'h0008, 32'h12BB_56DD);

    @(negedge clk);
    addr = 17'h0400; rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("unsel waitreq", {31'h0, waitreq}, 32'h1);
      chk("unsel rdatavld", {31'h0, rdatavld}, 32'h0);
    end
    rd = 1'b0;

    @(negedge clk);
    status = 32'hCAFE_F00D;
    do_read("rd_status", 17'h0004, 32'hCAFE_F00D);
    do_read("rd_id", 17'h0000, 32'hA1B0_0001);

    do_write("wr_reg3", 17'h000C, 32'h0000_0055, 4'b1111, 1'b0);
    chk("wr_reg3 value", ctrl_regs[63:32], 32'h0000_0055);
    chk("wr_reg3 reg2 kept", ctrl_regs[31:0], 32'h12BB_56DD);

    do_write("wr_id", 17'h0000, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    do_read("rd_id_after_wr", 17'h0000, 32'hA1B0_0001);
    do_read("rd_alias_id", 17'h0020, 32'hA1B0_0001);
    do_read("rd_alias_reg2", 17'h0028, 32'h12BB_56DD);

    do_write("be_zero", 17'h0008, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    chk("be_zero value", ctrl_regs[31:0], 32'h12BB_56DD);

    do_write("coll", 17'h0010, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("coll no rdatavld", {31'h0, rdatavld}, 32'h0);
      @(negedge clk);
    end
    chk("coll value", ctrl_regs[95:64], 32'hDEAD_BEEF);

    @(negedge clk);
    addr = 17'h0008; wdata = 32'h0; be = 4'b1111; wr = 1'b1;
    wait_ack("drop");
    wr = 1'b0;
    @(negedge clk);
    chk("drop waitreq", {31'h0, waitreq}, 32'h1);
    @(negedge clk);
    chk("drop value", ctrl_regs[31:0], 32'h12BB_56DD);

    @(negedge clk);
    addr = 17'h0008; rd = 1'b1;
    wait_ack("rst_mid");
    @(posedge clk);
    #1 rd = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid no rdatavld", {31'h0, rdatavld}, 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid waitreq", {31'h0, waitreq}, 32'h1);
    chk("rst_mid reg3", ctrl_regs[63:32], 32'h0);
    do_read("rd_after_rst", 17'h0008, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
